controller_reader: RTL

- Console-side master for the serial game controllers.
- Generates the shared latch and controller clock and shifts in each controller's active-low data line.
- Presents each controller's 8 buttons as an active-high parallel byte to the memory-mapped I/O layer.
- A scan starts on a start pulse, typically tied to vblank.

---
 rtl/controller_reader_pkg.sv | 24 ++
 rtl/controller_reader_bit_synchronizer.sv | 31 +++
 rtl/controller_reader.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/controller_reader_pkg.sv
// Shared types and constants for the serial game-controller reader.
package controller_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LOW,
    HIGH,
    DONE
  } state_t;

  localparam int BITS_PER_CTRL = 8;

  // Bit positions inside a button byte; bit 7 is the first bit on the wire.
  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

endpackage

// File: rtl/controller_reader_bit_synchronizer.sv
// Parameterized-width 2-flop synchronizer; resets to all ones (idle-high line).
module bit_synchronizer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/controller_reader.sv
// Console-side master for serial game controllers: drives latch/ctrl_clk, shifts in data_B.
// Optional macro CONTROLLER_READER_SYNC_LATCH_EN adds a ctrl_clk rise inside latch for sync-load pads.
module controller_reader
  import controller_reader_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int NUM_CTRL = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [NUM_CTRL-1:0]                     data_B,
  output logic                                    latch,
  output logic                                    ctrl_clk,
  output logic [NUM_CTRL-1:0][BITS_PER_CTRL-1:0]  buttons,
  output logic                                    valid,
  output logic                                    busy
);

  if (CLK_DIV < 3) begin : g_bad_clk_div
    $error("controller_reader: CLK_DIV must be 3 or more");
  end

`ifdef CONTROLLER_READER_SYNC_LATCH_EN
  localparam int LATCH_CYCLES = 2 * CLK_DIV;
`else
  localparam int LATCH_CYCLES = CLK_DIV;
`endif
  localparam int PW = $clog2(2 * CLK_DIV);
  localparam int BW = $clog2(BITS_PER_CTRL);
  localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] LATCH_LAST = PW'(LATCH_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(BITS_PER_CTRL - 1);
`ifdef CONTROLLER_READER_SYNC_LATCH_EN
  localparam logic [PW-1:0] PHASE_HALF = PW'(CLK_DIV);
`endif

  state_t                                 state_d, state_q;
  logic [PW-1:0]                          phase_d, phase_q;
  logic [BW-1:0]                          bit_d, bit_q;
  logic [NUM_CTRL-1:0][BITS_PER_CTRL-1:0] shift_d, shift_q;
  logic [NUM_CTRL-1:0][BITS_PER_CTRL-1:0] buttons_d, buttons_q;
  logic                                   latch_d, latch_q;
  logic                                   ctrl_clk_d, ctrl_clk_q;
  logic                                   valid_d, valid_q;
  logic                                   busy_d, busy_q;
  logic [NUM_CTRL-1:0]                    data_sync;

  bit_synchronizer #(
    .WIDTH (NUM_CTRL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (data_B),
    .q   (data_sync)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    buttons_d = buttons_q;

    unique case (state_q)
      IDLE: begin
        phase_d = '0;
        if (start) begin
          state_d = LATCH;
          bit_d   = '0;
        end
      end
      LATCH: begin
        if (phase_q == LATCH_LAST) begin
          state_d = LOW;
          phase_d = '0;
        end
      end
      LOW: begin
        if (phase_q == PHASE_LAST) begin
          phase_d = '0;
          for (int c = 0; c < NUM_CTRL; c++) begin
            shift_d[c] = {shift_q[c][BITS_PER_CTRL-2:0], data_sync[c]};
          end
          // Publish on DONE entry so buttons and valid appear in the same cycle.
          if (bit_q == BIT_LAST) begin
            state_d   = DONE;
            buttons_d = ~shift_d;
          end else begin
            state_d = HIGH;
          end
        end
      end
      HIGH: begin
        if (phase_q == PHASE_LAST) begin
          state_d = LOW;
          phase_d = '0;
          bit_d   = bit_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        phase_d = '0;
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase

    // Outputs are registered from the next state to keep the pad wires glitch-free.
    latch_d    = (state_d == LATCH);
    ctrl_clk_d = (state_d == HIGH);
`ifdef CONTROLLER_READER_SYNC_LATCH_EN
    if ((state_d == LATCH) && (phase_d >= PHASE_HALF)) begin
      ctrl_clk_d = 1'b1;
    end
`endif
    valid_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      bit_q      <= '0;
      shift_q    <= '1;
      buttons_q  <= '0;
      latch_q    <= 1'b0;
      ctrl_clk_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      buttons_q  <= buttons_d;
      latch_q    <= latch_d;
      ctrl_clk_q <= ctrl_clk_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign latch    = latch_q;
  assign ctrl_clk = ctrl_clk_q;
  assign buttons  = buttons_q;
  assign valid    = valid_q;
  assign busy     = busy_q;

endmodule
